chunk_burst_reader: RTL and testbench



---
 rtl/chunk_burst_reader_if.sv | 30 +++
 rtl/chunk_burst_reader.sv | 96 +++++++++
 tb/tb_chunk_burst_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_burst_reader_if.sv
// FIFO-side and burst-side signals of chunk_burst_reader, bundled.
// master: the reader; slave: the surrounding FIFO and sink.
interface chunk_burst_reader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0] fData;
    logic             fValid;
    logic             fValidChunk;
    logic [DEPTH-1:0] fLevel;
    logic             fReady;
    logic             flush;
    logic [WIDTH-1:0] oData;
    logic             oValid;
    logic             oSop;
    logic             oEop;
    logic             oReady;
    logic             busy;
    logic [15:0]      burstCount;

    modport master (
        input  fData, fValid, fValidChunk, fLevel, flush, oReady,
        output fReady, oData, oValid, oSop, oEop, busy, burstCount
    );

    modport slave (
        output fData, fValid, fValidChunk, fLevel, flush, oReady,
        input  fReady, oData, oValid, oSop, oEop, busy, burstCount
    );
endinterface

// File: rtl/chunk_burst_reader.sv
// Drains CHUNK-word (or flushed partial) bursts from a FIFO onto a registered SOP/EOP stream.
// First word 2 cycles after fValidChunk; pops stall while the output register is held by !oReady.
module chunk_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CHUNK = 4
) (
    input  logic                 sysClk,
    input  logic                 reset_n,
    chunk_burst_reader_if.master bus
);
    localparam int RW = $clog2(CHUNK) + 1;

    typedef enum logic [1:0] {IDLE, BURST, SHORT} state_t;

    state_t           state_q;
    logic [RW-1:0]    remain_q;
    logic             first_q;
    logic             flush_pend_q;
    logic [WIDTH-1:0] data_q;
    logic             vld_q;
    logic             sop_q;
    logic             eop_q;
    logic [15:0]      cnt_q;

    logic in_burst;
    logic pop;
    logic accept;

    assign in_burst = (state_q != IDLE);
    assign pop      = in_burst && bus.fValid && (remain_q != '0) && (!vld_q || bus.oReady);
    assign accept   = vld_q && bus.oReady;

    assign bus.fReady     = pop;
    assign bus.oData      = data_q;
    assign bus.oValid     = vld_q;
    assign bus.oSop       = sop_q;
    assign bus.oEop       = eop_q;
    assign bus.busy       = in_burst;
    assign bus.burstCount = cnt_q;

    always_ff @(posedge sysClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            remain_q     <= '0;
            first_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            vld_q        <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (pop) begin
                data_q   <= bus.fData;
                vld_q    <= 1'b1;
                sop_q    <= first_q;
                eop_q    <= (remain_q == RW'(1));
                remain_q <= remain_q - 1'b1;
                first_q  <= 1'b0;
            end else if (accept) begin
                vld_q <= 1'b0;
                sop_q <= 1'b0;
                eop_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // A full chunk always takes precedence over a pending flush.
                    if (bus.fValidChunk) begin
                        state_q  <= BURST;
                        remain_q <= RW'(CHUNK);
                        first_q  <= 1'b1;
                    end else if (flush_pend_q && (bus.fLevel != '0)) begin
                        state_q  <= SHORT;
                        remain_q <= bus.fLevel[RW-1:0];
                        first_q  <= 1'b1;
                    end
                end
                default: begin
                    if (accept && eop_q) begin
                        state_q <= IDLE;
                        cnt_q   <= cnt_q + 16'd1;
                    end
                end
            endcase

            // Without a full chunk, an idle cycle either starts the short burst or finds nothing to flush.
            if (bus.flush) begin
                flush_pend_q <= 1'b1;
            end else if ((state_q == IDLE) && !bus.fValidChunk) begin
                flush_pend_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_chunk_burst_reader.sv
// Bench for chunk_burst_reader: a queue-based FIFO, an in-order beat scoreboard and burst-length model.
module tb_chunk_burst_reader;
    localparam int CHUNK = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    logic sysClk = 1'b0;
    logic reset_n = 1'b0;

    chunk_burst_reader_if #(.WIDTH(8), .DEPTH(4)) bus ();

    chunk_burst_reader #(.WIDTH(8), .DEPTH(4), .CHUNK(CHUNK)) dut (
        .sysClk (sysClk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    always #5 sysClk = ~sysClk;

    logic [7:0] fifo_q[$];
    logic [7:0] pre_q[$];
    logic [7:0] trk_q[$];
    logic [7:0] inflight[$];
    int         lens[$];
    beat_t      log_q[$];

    bit   pop_s, flush_req, gate_en, rdy_rand, rdy_val;
    int   errors, checks, exp_cnt, idx;
    bit   prev_stall;
    beat_t prev_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive FIFO/sink inputs after the edge, then compare outputs at the falling edge.
    task automatic tick();
        bit gate;
        @(posedge sysClk);
        #1;
        if (pop_s && reset_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
        while (pre_q.size() > 0) fifo_q.push_back(pre_q.pop_front());
        if (trk_q.size() > 0 && $urandom_range(0, 1) == 1) fifo_q.push_back(trk_q.pop_front());
        gate = !gate_en || ($urandom_range(0, 3) != 0);
        bus.fData       = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        bus.fValid      = (fifo_q.size() > 0) && gate;
        bus.fValidChunk = (fifo_q.size() >= CHUNK);
        bus.fLevel      = 4'(fifo_q.size());
        bus.flush       = flush_req;
        flush_req       = 1'b0;
        bus.oReady      = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;

        @(negedge sysClk);
        if (!reset_n) begin
            inflight.delete();
            idx        = 0;
            exp_cnt    = 0;
            pop_s      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("fready_without_fvalid", 32'(bus.fReady && !bus.fValid), 0);
            chk("burst_count", 32'(bus.burstCount), 32'(exp_cnt));
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.oValid), 1);
                chk("hold_beat", 32'({bus.oData, bus.oSop, bus.oEop}), 32'(prev_b));
            end
            if (bus.oValid && bus.oReady) begin
                if (inflight.size() == 0 || lens.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h with no beat expected at %0t", bus.oData, $time);
                end else begin
                    chk("beat_data", 32'(bus.oData), 32'(inflight.pop_front()));
                    chk("beat_sop", 32'(bus.oSop), 32'(idx == 0));
                    chk("beat_eop", 32'(bus.oEop), 32'(idx == lens[0] - 1));
                    if (idx == lens[0] - 1) begin
                        idx = 0;
                        void'(lens.pop_front());
                        exp_cnt++;
                    end else begin
                        idx++;
                    end
                end
                log_q.push_back({bus.oData, bus.oSop, bus.oEop});
            end
            prev_stall = bus.oValid && !bus.oReady;
            prev_b     = {bus.oData, bus.oSop, bus.oEop};
            if (bus.fReady) inflight.push_back(bus.fData);
            pop_s = bus.fReady;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(bus.busy == 1'b0 && lens.size() == 0 && trk_q.size() == 0 &&
                 pre_q.size() == 0 && fifo_q.size() < CHUNK) && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy=%0b with %0d bursts outstanding", name, bus.busy, lens.size());
        end
    endtask

    task automatic do_flush(input string name);
        wait_idle({name, "_pre"});
        if (fifo_q.size() > 0) lens.push_back(fifo_q.size());
        flush_req = 1'b1;
        repeat (3) tick();
        wait_idle(name);
    endtask

    task automatic preload(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input logic [7:0] w3, input logic [7:0] w4, input int n);
        logic [7:0] w[5];
        w = '{w0, w1, w2, w3, w4};
        for (int i = 0; i < n; i++) pre_q.push_back(w[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] first_left;
        bus.fData = '0; bus.fValid = 0; bus.fValidChunk = 0; bus.fLevel = '0;
        bus.flush = 0; bus.oReady = 0;
        rdy_val = 1'b1;

        // Reset and idle
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outputs", 32'({bus.oValid, bus.oSop, bus.oEop, bus.busy, bus.fReady}), 0);
            chk("idle_data", 32'(bus.oData), 0);
            chk("idle_count", 32'(bus.burstCount), 0);
        end

        // Full chunk with literal cycle timing
        log_q.delete();
        lens.push_back(4);
        preload(8'h94, 8'h5D, 8'hFD, 8'h4F, 8'h41, 5);
        tick(); chk("lat_c1_fready", 32'(bus.fReady), 0); chk("lat_c1_busy", 32'(bus.busy), 0);
        tick(); chk("lat_c2_fready", 32'(bus.fReady), 1); chk("lat_c2_ovalid", 32'(bus.oValid), 0);
        tick(); chk("lat_c3_beat", 32'({bus.oValid, bus.oData, bus.oSop, bus.oEop}), {23'd0, 1'b1, 8'h94, 2'b10});
        tick(); chk("lat_c4_beat", 32'({bus.oValid, bus.oData, bus.oSop, bus.oEop}), {23'd0, 1'b1, 8'h5D, 2'b00});
        tick(); chk("lat_c5_beat", 32'({bus.oValid, bus.oData, bus.oSop, bus.oEop}), {23'd0, 1'b1, 8'hFD, 2'b00});
        tick(); chk("lat_c6_beat", 32'({bus.oValid, bus.oData, bus.oSop, bus.oEop}), {23'd0, 1'b1, 8'h4F, 2'b01});
        tick(); chk("chunk_count", 32'(bus.burstCount), 1); chk("chunk_busy", 32'(bus.busy), 0);
        chk("chunk_left", 32'(fifo_q.size()), 1);
        do_flush("drain_41");

        // Backpressure on the SOP word
        log_q.delete();
        rdy_val = 1'b0;
        lens.push_back(4);
        preload(8'h94, 8'h5D, 8'hFD, 8'h4F, 8'h41, 5);
        n = 0;
        while (!(bus.oValid && bus.oSop) && n < 20) begin tick(); n++; end
        chk("bp_sop_seen", 32'(n < 20), 1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("bp_hold_data", 32'(bus.oData), 32'h94);
            chk("bp_fready_low", 32'(bus.fReady), 0);
        end
        rdy_val = 1'b1;
        wait_idle("bp");
        chk("bp_len", 32'(log_q.size()), 4);
        if (log_q.size() == 4) chk("bp_last", 32'(log_q[3]), {22'd0, 8'h4F, 2'b01});
        do_flush("bp_drain");

        // Flush of a partial chunk, then a flush with nothing queued
        log_q.delete();
        preload(8'h31, 8'hAB, 8'h00, 8'h00, 8'h00, 2);
        repeat (5) tick();
        chk("partial_waits", 32'(log_q.size()), 0);
        n = bus.burstCount;
        do_flush("flush2");
        chk("flush_len", 32'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            chk("flush_b0", 32'(log_q[0]), {22'd0, 8'h31, 2'b10});
            chk("flush_b1", 32'(log_q[1]), {22'd0, 8'hAB, 2'b01});
        end
        chk("flush_count", 32'(bus.burstCount), 32'(n + 1));
        flush_req = 1'b1;
        repeat (5) tick();
        preload(8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 2);
        repeat (10) tick();
        chk("empty_flush_cleared", 32'(log_q.size()), 2);
        do_flush("flush_22");

        // Chunk wins over a simultaneous flush
        log_q.delete();
        lens.push_back(4);
        lens.push_back(2);
        preload(8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 5);
        pre_q.push_back(8'hC5);
        flush_req = 1'b1;
        wait_idle("prio");
        chk("prio_len", 32'(log_q.size()), 6);
        if (log_q.size() == 6) begin
            chk("prio_b0", 32'(log_q[0]), {22'd0, 8'hC0, 2'b10});
            chk("prio_b3", 32'(log_q[3]), {22'd0, 8'hC3, 2'b01});
            chk("prio_b4", 32'(log_q[4]), {22'd0, 8'hC4, 2'b10});
            chk("prio_b5", 32'(log_q[5]), {22'd0, 8'hC5, 2'b01});
        end

        // Reset in the middle of a burst
        log_q.delete();
        lens.push_back(4);
        lens.push_back(4);
        preload(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 5);
        preload(8'hA5, 8'hA6, 8'hA7, 8'h00, 8'h00, 3);
        n = 0;
        while (log_q.size() < 2 && n < 30) begin tick(); n++; end
        chk("rst_two_beats", 32'(log_q.size()), 2);
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({bus.oValid, bus.oSop, bus.oEop, bus.busy, bus.fReady}), 0);
        chk("rst_data", 32'(bus.oData), 0);
        chk("rst_count", 32'(bus.burstCount), 0);
        lens.delete();
        repeat (3) tick();
        for (int i = 0; i < fifo_q.size() / CHUNK; i++) lens.push_back(CHUNK);
        first_left = fifo_q[0];
        log_q.delete();
        reset_n = 1'b1;
        wait_idle("post_rst");
        chk("post_rst_first", 32'(log_q.size() > 0 ? log_q[0] : beat_t'(0)), {22'd0, first_left, 2'b10});
        do_flush("post_rst_drain");

        // Randomized rounds: trickled pushes, stalling head, random sink
        rdy_rand = 1'b1;
        gate_en  = 1'b1;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) trk_q.push_back(8'($urandom));
            for (int i = 0; i < n / CHUNK; i++) lens.push_back(CHUNK);
            do_flush("rand");
        end
        chk("rand_fifo_empty", 32'(fifo_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
